// File: rtl/cc_register_bank_pkg.sv
// Shared datapath constants for the load mux/decoder stage and the register bank.
package cc_register_bank_pkg;
    localparam int DATAWIDTH_BUS           = 32;
    localparam int DATAWIDTH_DECODER_OUT   = 14;
    localparam int DATAWIDTH_MIR_DIRECTION = 6;
    localparam int REG_BASE_ADDR           = 2;
    localparam logic [DATAWIDTH_DECODER_OUT-1:0] LOAD_NONE = 14'h3FFF;

    localparam int CNT_W = $clog2(DATAWIDTH_DECODER_OUT + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [DATAWIDTH_DECODER_OUT-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATAWIDTH_DECODER_OUT; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/cc_regbank_readport.sv
// One combinational read port: range check, index mux, zero default, write forwarding.
module cc_regbank_readport
    import cc_register_bank_pkg::*;
#(
    parameter int W         = DATAWIDTH_BUS,
    parameter int N         = DATAWIDTH_DECODER_OUT,
    parameter int AW        = DATAWIDTH_MIR_DIRECTION,
    parameter int BASE      = REG_BASE_ADDR,
    parameter int BYPASS_EN = 1
) (
    input  logic [AW-1:0]       addr,
    input  logic [N-1:0][W-1:0] regs,
    input  logic [W-1:0]        wr_data,
    input  logic                wr_en,
    input  logic [N-1:0]        wr_sel,
    output logic [W-1:0]        data
);
    // Compare at 32 bits so an out-of-range address can never alias onto a register.
    always_comb begin
        data = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(addr) == 32'(BASE + i)) begin
                if (BYPASS_EN != 0 && wr_en && wr_sel[i]) data = wr_data;
                else                                       data = regs[i];
            end
        end
    end
endmodule

// File: rtl/cc_register_bank.sv
// General-purpose register bank: 14 registers at MIR addresses 2..15, two read ports, load-bus legality flag.
module cc_register_bank
    import cc_register_bank_pkg::*;
#(
    parameter int                       DW          = DATAWIDTH_BUS,
    parameter int                       NREG        = DATAWIDTH_DECODER_OUT,
    parameter int                       AW          = DATAWIDTH_MIR_DIRECTION,
    parameter int                       BASE        = REG_BASE_ADDR,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_VALUE = '0,
    parameter int                       BYPASS_EN   = 1
) (
    input  logic            CC_REGBANK_CLOCK_50,
    input  logic            CC_REGBANK_RESET_InLow,
    input  logic [DW-1:0]   CC_REGBANK_data_InBus,
    input  logic [NREG-1:0] CC_REGBANK_Load_InBus,
    input  logic [AW-1:0]   CC_REGBANK_AddrA_InBus,
    input  logic [AW-1:0]   CC_REGBANK_AddrB_InBus,
    output logic [DW-1:0]   CC_REGBANK_DataA_OutBus,
    output logic [DW-1:0]   CC_REGBANK_DataB_OutBus,
    output logic            CC_REGBANK_Written_Out,
    output logic            CC_REGBANK_LoadErr_Out
);
    logic [NREG-1:0]          wr_sel;
    logic [CNT_W-1:0]         hot_cnt;
    logic                     wr_legal;
    logic                     wr_multi;
    logic [NREG-1:0][DW-1:0]  regs;
    logic                     written;
    logic                     load_err;

    assign wr_sel   = ~CC_REGBANK_Load_InBus;
    assign hot_cnt  = popcount(wr_sel);
    assign wr_legal = (hot_cnt == CNT_W'(1));
    assign wr_multi = (hot_cnt > CNT_W'(1));

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        always_ff @(posedge CC_REGBANK_CLOCK_50 or negedge CC_REGBANK_RESET_InLow) begin
            if (!CC_REGBANK_RESET_InLow)     regs[i] <= RESET_VALUE[DW-1:0];
            else if (wr_legal && wr_sel[i])  regs[i] <= CC_REGBANK_data_InBus;
        end
    end

    // Error flag is sticky until reset; Written tracks only the last edge.
    always_ff @(posedge CC_REGBANK_CLOCK_50 or negedge CC_REGBANK_RESET_InLow) begin
        if (!CC_REGBANK_RESET_InLow) begin
            written  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            written  <= wr_legal;
            load_err <= load_err | wr_multi;
        end
    end

    assign CC_REGBANK_Written_Out = written;
    assign CC_REGBANK_LoadErr_Out = load_err;

    cc_regbank_readport #(
        .W(DW), .N(NREG), .AW(AW), .BASE(BASE), .BYPASS_EN(BYPASS_EN)
    ) u_port_a (
        .addr    (CC_REGBANK_AddrA_InBus),
        .regs    (regs),
        .wr_data (CC_REGBANK_data_InBus),
        .wr_en   (wr_legal),
        .wr_sel  (wr_sel),
        .data    (CC_REGBANK_DataA_OutBus)
    );

    cc_regbank_readport #(
        .W(DW), .N(NREG), .AW(AW), .BASE(BASE), .BYPASS_EN(BYPASS_EN)
    ) u_port_b (
        .addr    (CC_REGBANK_AddrB_InBus),
        .regs    (regs),
        .wr_data (CC_REGBANK_data_InBus),
        .wr_en   (wr_legal),
        .wr_sel  (wr_sel),
        .data    (CC_REGBANK_DataB_OutBus)
    );
endmodule

// File: tb/tb_cc_register_bank.sv
// Directed bench for cc_register_bank with a queue scoreboard; a second instance has forwarding disabled.
module tb_cc_register_bank;
    import cc_register_bank_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [13:0] load;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] da, db, da_nb, db_nb;
    logic        wr, err, wr_nb, err_nb;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cc_register_bank #(.BYPASS_EN(1)) dut (
        .CC_REGBANK_CLOCK_50     (clk),
        .CC_REGBANK_RESET_InLow  (rst_n),
        .CC_REGBANK_data_InBus   (data),
        .CC_REGBANK_Load_InBus   (load),
        .CC_REGBANK_AddrA_InBus  (addr_a),
        .CC_REGBANK_AddrB_InBus  (addr_b),
        .CC_REGBANK_DataA_OutBus (da),
        .CC_REGBANK_DataB_OutBus (db),
        .CC_REGBANK_Written_Out  (wr),
        .CC_REGBANK_LoadErr_Out  (err)
    );

    cc_register_bank #(.BYPASS_EN(0)) dut_nb (
        .CC_REGBANK_CLOCK_50     (clk),
        .CC_REGBANK_RESET_InLow  (rst_n),
        .CC_REGBANK_data_InBus   (data),
        .CC_REGBANK_Load_InBus   (load),
        .CC_REGBANK_AddrA_InBus  (addr_a),
        .CC_REGBANK_AddrB_InBus  (addr_b),
        .CC_REGBANK_DataA_OutBus (da_nb),
        .CC_REGBANK_DataB_OutBus (db_nb),
        .CC_REGBANK_Written_Out  (wr_nb),
        .CC_REGBANK_LoadErr_Out  (err_nb)
    );

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, expected nothing queued", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic [13:0] l, input logic [31:0] d,
                         input logic [5:0] a, input logic [5:0] b);
        load = l; data = d; addr_a = a; addr_b = b;
        #1;
    endtask

    // Advance through a rising edge and settle 2 time units past it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(LOAD_NONE, 32'h0, 6'd2, 6'd15);
        repeat (2) @(posedge clk);
        #2;

        // 1: reset state, during and after reset
        expect_val("rst_a", 32'h0);   check(da);
        expect_val("rst_b", 32'h0);   check(db);
        expect_val("rst_wr", 32'h0);  check({31'b0, wr});
        expect_val("rst_err", 32'h0); check({31'b0, err});
        rst_n = 1'b1;
        tick();
        expect_val("rel_a", 32'h0);   check(da);
        expect_val("rel_b", 32'h0);   check(db);
        expect_val("rel_wr", 32'h0);  check({31'b0, wr});

        // 2: single write to addr 2
        drive(14'h3FFE, 32'hDEADBEEF, 6'd3, 6'd15);
        tick();
        drive(LOAD_NONE, 32'h0, 6'd2, 6'd15);
        expect_val("wr2_a", 32'hDEADBEEF); check(da);
        expect_val("wr2_nb_a", 32'hDEADBEEF); check(da_nb);
        expect_val("wr2_written", 32'h1); check({31'b0, wr});
        tick();
        expect_val("wr2_written_drop", 32'h0); check({31'b0, wr});

        // 3: forwarding on A=B=15
        drive(14'h1FFF, 32'h12345678, 6'd15, 6'd15);
        expect_val("byp_a", 32'h12345678); check(da);
        expect_val("byp_b", 32'h12345678); check(db);
        expect_val("nobyp_a", 32'h0);      check(da_nb);
        expect_val("nobyp_b", 32'h0);      check(db_nb);
        tick();
        drive(LOAD_NONE, 32'h0, 6'd15, 6'd2);
        expect_val("nobyp_after_a", 32'h12345678); check(da_nb);
        expect_val("byp_after_b", 32'hDEADBEEF);   check(db);

        // 4: multi-hot load is rejected, flag is sticky
        drive(14'h3FFC, 32'hFFFFFFFF, 6'd2, 6'd3);
        expect_val("mh_nobyp_a", 32'hDEADBEEF); check(da);
        expect_val("mh_nobyp_b", 32'h0);        check(db);
        tick();
        drive(LOAD_NONE, 32'h0, 6'd2, 6'd3);
        expect_val("mh_r2", 32'hDEADBEEF); check(da);
        expect_val("mh_r3", 32'h0);        check(db);
        expect_val("mh_err", 32'h1);       check({31'b0, err});
        expect_val("mh_written", 32'h0);   check({31'b0, wr});
        drive(14'h3FFD, 32'h33, 6'd2, 6'd3);
        tick();
        drive(LOAD_NONE, 32'h0, 6'd2, 6'd3);
        expect_val("sticky_err", 32'h1);   check({31'b0, err});
        expect_val("sticky_wr", 32'h1);    check({31'b0, wr});
        expect_val("sticky_r3", 32'h33);   check(db);
        expect_val("nb_err", 32'h1);       check({31'b0, err_nb});

        // 5: out-of-range addresses read zero, even while a write to addr 2 is pending
        begin
            logic [5:0] oor [4];
            oor = '{6'd0, 6'd1, 6'd16, 6'd63};
            for (int k = 0; k < 4; k++) begin
                drive(14'h3FFE, 32'hCAFEF00D, oor[k], 6'd2);
                expect_val($sformatf("oor_%0d", oor[k]), 32'h0); check(da);
                expect_val($sformatf("oor_%0d_b", oor[k]), 32'hCAFEF00D); check(db);
            end
            drive(LOAD_NONE, 32'h0, 6'd2, 6'd2);
        end

        // 6: fill all registers with their own address, then async reset
        for (int i = 0; i < 14; i++) begin
            drive(~(14'h1 << i), 32'(i + 2), 6'd0, 6'd0);
            tick();
        end
        drive(LOAD_NONE, 32'h0, 6'd0, 6'd0);
        for (int i = 0; i < 14; i++) begin
            addr_a = 6'(i + 2); addr_b = 6'(i + 2);
            #1;
            expect_val($sformatf("fill_a_%0d", i + 2), 32'(i + 2)); check(da);
            expect_val($sformatf("fill_b_%0d", i + 2), 32'(i + 2)); check(db_nb);
        end
        drive(14'h3FFE, 32'hAAAA5555, 6'd3, 6'd15);
        rst_n = 1'b0;
        #1;
        expect_val("arst_wr", 32'h0);  check({31'b0, wr});
        expect_val("arst_err", 32'h0); check({31'b0, err});
        expect_val("arst_nb_err", 32'h0); check({31'b0, err_nb});
        expect_val("arst_b15", 32'h0); check(db);
        for (int i = 0; i < 14; i++) begin
            addr_a = 6'(i + 2);
            #1;
            expect_val($sformatf("arst_nb_%0d", i + 2), 32'h0); check(da_nb);
        end
        tick();
        drive(LOAD_NONE, 32'h0, 6'd2, 6'd15);
        rst_n = 1'b1;
        #1;
        expect_val("arst_r2", 32'h0); check(da);
        tick();
        expect_val("post_rst_wr", 32'h0); check({31'b0, wr});

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no completion, expected finish");
        $fatal(1, "timeout");
    end
endmodule
